// File: rtl/lvds_rx_pa_pkg.sv
// Shared types and constants for the LVDS receiver phase-alignment block.
package lvds_rx_pa_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLock,
    StSettle,
    StSample,
    StNext,
    StEval,
    StDone,
    StFail
  } pa_state_e;

  localparam int unsigned PHASE_STEPS       = 16;
  localparam logic [3:0]  DUTYDA_DEFAULT    = 4'b1000;
  localparam logic [6:0]  TRAIN_PAT_DEFAULT = 7'b1100011;

  // Centre of a run: start + (len-1)/2, wrapping modulo 16.
  function automatic logic [3:0] run_centre(input logic [3:0] start, input logic [4:0] len);
    logic [4:0] half;
    half = (len - 5'd1) >> 1;
    return start + half[3:0];
  endfunction

endpackage

// File: rtl/lvds_rx_eye_search.sv
// Longest run of ones in a 16-bit pass map, optionally circular; ties go to the lowest start.
module lvds_rx_eye_search
  import lvds_rx_pa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        wrap_i,
  input  logic [15:0] map_i,
  output logic [3:0]  run_start_o,
  output logic [4:0]  run_len_o,
  output logic        valid_o
);

  logic       busy_q, busy_d, wrap_q, wrap_d, valid_q, valid_d;
  logic [4:0] idx_q, idx_d, cur_len_q, cur_len_d, best_len_q, best_len_d;
  logic [3:0] cur_start_q, cur_start_d, best_start_q, best_start_d;

  // Circular mode walks the map twice so a run crossing bit 15 -> bit 0 is seen whole;
  // run length saturates at 16 so an all-ones map reports start 0.
  always_comb begin
    busy_d       = busy_q;
    wrap_d       = wrap_q;
    valid_d      = 1'b0;
    idx_d        = idx_q;
    cur_len_d    = cur_len_q;
    cur_start_d  = cur_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    if (start_i) begin
      busy_d       = 1'b1;
      wrap_d       = wrap_i;
      idx_d        = '0;
      cur_len_d    = '0;
      cur_start_d  = '0;
      best_len_d   = '0;
      best_start_d = '0;
    end else if (busy_q) begin
      if (map_i[idx_q[3:0]]) begin
        if (cur_len_q == 5'd0) begin
          cur_start_d = idx_q[3:0];
          cur_len_d   = 5'd1;
        end else if (cur_len_q != 5'd16) begin
          cur_len_d = cur_len_q + 5'd1;
        end
        if (cur_len_d > best_len_q) begin
          best_len_d   = cur_len_d;
          best_start_d = cur_start_d;
        end
      end else begin
        cur_len_d = '0;
      end
      idx_d = idx_q + 5'd1;
      if (idx_q == (wrap_q ? 5'd31 : 5'd15)) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      wrap_q       <= 1'b0;
      valid_q      <= 1'b0;
      idx_q        <= '0;
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
    end else begin
      busy_q       <= busy_d;
      wrap_q       <= wrap_d;
      valid_q      <= valid_d;
      idx_q        <= idx_d;
      cur_len_q    <= cur_len_d;
      cur_start_q  <= cur_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
    end
  end

  assign run_start_o = best_start_q;
  assign run_len_o   = best_len_q;
  assign valid_o     = valid_q;

endmodule

// File: rtl/lvds_rx_phase_align.sv
// Sweeps the PLL coarse phase, scores each step on the training word and parks on the eye centre.
// Define PHASE_ALIGN_FDLY_SWEEP_EN to add a fine-delay sweep after the coarse pass.
module lvds_rx_phase_align
  import lvds_rx_pa_pkg::*;
#(
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       WORD_W     = 7,
  parameter logic [WORD_W-1:0] TRAIN_PAT  = WORD_W'(TRAIN_PAT_DEFAULT),
  parameter int unsigned       SETTLE_CYC = 64,
  parameter int unsigned       SAMPLE_CNT = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pll_lock,
  input  logic                     start,
  input  logic [NUM_CH*WORD_W-1:0] rx_data,
  output logic [3:0]               psda,
  output logic [3:0]               dutyda,
  output logic [3:0]               fdly,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [3:0]               best_phase,
  output logic [4:0]               eye_width,
  output logic [15:0]              phase_ok_map
);

`ifdef PHASE_ALIGN_FDLY_SWEEP_EN
  localparam bit FineSweepEn = 1'b1;
`else
  localparam bit FineSweepEn = 1'b0;
`endif

  localparam int unsigned CntMax   = (SETTLE_CYC > SAMPLE_CNT) ? SETTLE_CYC : SAMPLE_CNT;
  localparam int unsigned CntW     = $clog2(CntMax + 1);
  localparam logic [3:0]  LastStep = 4'(PHASE_STEPS - 1);

  pa_state_e   state_q, state_d;
  logic [3:0]  psda_q, psda_d, fdly_q, fdly_d, best_phase_q, best_phase_d;
  logic [4:0]  eye_width_q, eye_width_d;
  logic [15:0] map_q, map_d, fmap_q, fmap_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic        pass_q, pass_d, fine_q, fine_d;
  logic        all_match, restart, es_start, es_valid;
  logic [3:0]  es_run_start, es_centre;
  logic [4:0]  es_run_len;

  always_comb begin
    all_match = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rx_data[ch*WORD_W +: WORD_W] != TRAIN_PAT) all_match = 1'b0;
    end
  end

  assign es_centre = run_centre(es_run_start, es_run_len);

  always_comb begin
    state_d      = state_q;
    psda_d       = psda_q;
    fdly_d       = fdly_q;
    best_phase_d = best_phase_q;
    eye_width_d  = eye_width_q;
    map_d        = map_q;
    fmap_d       = fmap_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    pass_d       = pass_q;
    fine_d       = fine_q;
    restart      = 1'b0;
    es_start     = 1'b0;
    unique case (state_q)
      StIdle:     restart = start;
      StWaitLock: begin
        if (pll_lock) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (cnt_q == CntW'(SETTLE_CYC - 1)) begin
          state_d = StSample;
          cnt_d   = '0;
          pass_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSample: begin
        pass_d = pass_q & all_match;
        if (cnt_q == CntW'(SAMPLE_CNT - 1)) state_d = StNext;
        else cnt_d = cnt_q + CntW'(1);
      end
      StNext: begin
        cnt_d = '0;
        if (fine_q) begin
          fmap_d[fdly_q] = pass_q;
          if (fdly_q != LastStep) begin
            fdly_d  = fdly_q + 4'd1;
            state_d = StSettle;
          end else begin
            state_d  = StEval;
            es_start = 1'b1;
          end
        end else begin
          map_d[psda_q] = pass_q;
          if (psda_q != LastStep) begin
            psda_d  = psda_q + 4'd1;
            state_d = StSettle;
          end else begin
            state_d  = StEval;
            es_start = 1'b1;
          end
        end
      end
      StEval: begin
        if (es_valid) begin
          if (fine_q) begin
            // A fine sweep with no passing step still reports success on the coarse result.
            fdly_d  = (es_run_len != 5'd0) ? es_centre : 4'd0;
            fine_d  = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
          end else if (es_run_len == 5'd0) begin
            psda_d       = '0;
            best_phase_d = '0;
            eye_width_d  = '0;
            fail_d       = 1'b1;
            busy_d       = 1'b0;
            state_d      = StFail;
          end else begin
            psda_d       = es_centre;
            best_phase_d = es_centre;
            eye_width_d  = es_run_len;
            if (FineSweepEn) begin
              fine_d  = 1'b1;
              fdly_d  = '0;
              fmap_d  = '0;
              cnt_d   = '0;
              state_d = StSettle;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = StDone;
            end
          end
        end
      end
      StDone:  restart = start | ~pll_lock;
      StFail:  restart = start;
      default: state_d = StIdle;
    endcase

    // Losing lock mid-sweep throws away everything gathered so far.
    if (restart || (!pll_lock &&
        (state_q inside {StWaitLock, StSettle, StSample, StNext, StEval}))) begin
      state_d      = StWaitLock;
      psda_d       = '0;
      fdly_d       = '0;
      best_phase_d = '0;
      eye_width_d  = '0;
      map_d        = '0;
      fmap_d       = '0;
      cnt_d        = '0;
      pass_d       = 1'b0;
      fine_d       = 1'b0;
      busy_d       = 1'b1;
      done_d       = 1'b0;
      fail_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      psda_q       <= '0;
      fdly_q       <= '0;
      best_phase_q <= '0;
      eye_width_q  <= '0;
      map_q        <= '0;
      fmap_q       <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      pass_q       <= 1'b0;
      fine_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      psda_q       <= psda_d;
      fdly_q       <= fdly_d;
      best_phase_q <= best_phase_d;
      eye_width_q  <= eye_width_d;
      map_q        <= map_d;
      fmap_q       <= fmap_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      pass_q       <= pass_d;
      fine_q       <= fine_d;
    end
  end

  lvds_rx_eye_search u_eye_search (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (es_start),
    .wrap_i      (~fine_q),
    .map_i       (fine_q ? fmap_q : map_q),
    .run_start_o (es_run_start),
    .run_len_o   (es_run_len),
    .valid_o     (es_valid)
  );

  assign psda         = psda_q;
  assign dutyda       = DUTYDA_DEFAULT;
  assign fdly         = fdly_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign best_phase   = best_phase_q;
  assign eye_width    = eye_width_q;
  assign phase_ok_map = map_q;

endmodule

// File: tb/tb_lvds_rx_phase_align.sv
// Randomised bench: a channel model drives training words by the DUT's current phase and a
// reference eye finder predicts the alignment result.
module tb_lvds_rx_phase_align;

  localparam int unsigned NCh    = 4;
  localparam int unsigned WW     = 7;
  localparam int unsigned Settle = 8;
  localparam int unsigned Samp   = 16;
  localparam logic [WW-1:0] Pat  = 7'b1100011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_lock = 1'b0;
  logic start = 1'b0;
  logic [NCh*WW-1:0] rx_data;
  logic [3:0]  psda, dutyda, fdly, best_phase;
  logic        busy, done, fail;
  logic [4:0]  eye_width;
  logic [15:0] phase_ok_map;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Channel plan: good_mask[p] says phase p sees clean training words.
  logic [15:0] good_mask = '0;
  bit          corrupt_en = 1'b0;
  int          corrupt_ph = 6;
  int          corrupt_k = 0;
  int          k = 0;
  logic [3:0]  last_psda = '0;

  always #5 clk = ~clk;

  lvds_rx_phase_align #(
    .NUM_CH     (NCh),
    .WORD_W     (WW),
    .TRAIN_PAT  (Pat),
    .SETTLE_CYC (Settle),
    .SAMPLE_CNT (Samp)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .start        (start),
    .rx_data      (rx_data),
    .psda         (psda),
    .dutyda       (dutyda),
    .fdly         (fdly),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .best_phase   (best_phase),
    .eye_width    (eye_width),
    .phase_ok_map (phase_ok_map)
  );

  // k counts cycles since psda last changed; k == n means the data is sampled at the n-th
  // edge after the change. Edges 1..Settle are settling, the next Samp edges are sampled.
  always @(negedge clk) begin
    logic [NCh*WW-1:0] w;
    logic [WW-1:0]     r;
    int                bad_ch;
    if (psda !== last_psda) k = 1;
    else k = k + 1;
    last_psda = psda;
    if (psda != 4'd0 && k <= Settle) begin
      for (int ch = 0; ch < NCh; ch++) w[ch*WW +: WW] = WW'($urandom);
    end else if (good_mask[psda]) begin
      for (int ch = 0; ch < NCh; ch++) w[ch*WW +: WW] = Pat;
      if (corrupt_en && int'(psda) == corrupt_ph && k == corrupt_k) begin
        r = WW'($urandom_range(1, 127));
        w[2*WW +: WW] = Pat ^ r;
      end
    end else begin
      for (int ch = 0; ch < NCh; ch++) w[ch*WW +: WW] = WW'($urandom);
      bad_ch = $urandom_range(0, NCh - 1);
      r = WW'($urandom_range(1, 127));
      w[bad_ch*WW +: WW] = Pat ^ r;
    end
    rx_data = w;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: enumerate every maximal circular run, keep the longest, lowest start on ties.
  function automatic void eye_model(input logic [15:0] m, output int st, output int len);
    int l;
    st  = 0;
    len = 0;
    if (m == 16'hFFFF) begin
      len = 16;
      return;
    end
    for (int s = 0; s < 16; s++) begin
      if (m[s] && !m[(s + 15) % 16]) begin
        l = 0;
        while (m[(s + l) % 16]) l++;
        if (l > len) begin
          len = l;
          st  = s;
        end
      end
    end
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end();
    int waited = 0;
    while (!(done || fail) && waited < 3000) begin
      tick();
      waited++;
    end
    check_eq("sweep_end", 32'(done | fail), 32'd1);
  endtask

  task automatic wait_phase(input int ph, input int kk);
    int  waited = 0;
    bit  found = 1'b0;
    while (!found && waited < 3000) begin
      tick();
      waited++;
      if (int'(psda) == ph && k == kk) found = 1'b1;
    end
    check_eq("reach_phase", 32'(found), 32'd1);
  endtask

  task automatic check_result(input logic [15:0] eff, input string tag);
    int         st, len;
    logic [3:0] bp;
    eye_model(eff, st, len);
    bp = (len > 0) ? 4'((st + (len - 1) / 2) % 16) : 4'd0;
    check_eq({tag, "_map"}, 32'(phase_ok_map), 32'(eff));
    check_eq({tag, "_eye"}, 32'(eye_width), 32'(len));
    check_eq({tag, "_best"}, 32'(best_phase), 32'(bp));
    check_eq({tag, "_psda"}, 32'(psda), 32'(bp));
    check_eq({tag, "_done"}, 32'(done), 32'(len > 0));
    check_eq({tag, "_fail"}, 32'(fail), 32'(len == 0));
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_fdly"}, 32'(fdly), 32'd0);
    check_eq({tag, "_dutyda"}, 32'(dutyda), 32'h8);
  endtask

  task automatic run_sweep(input logic [15:0] mask, input bit cor, input string tag);
    logic [15:0] eff;
    good_mask  = mask;
    corrupt_en = cor;
    corrupt_k  = Settle + 1 + $urandom_range(0, Samp - 1);
    eff = mask;
    if (cor) eff[corrupt_ph] = 1'b0;
    pulse_start();
    check_eq({tag, "_busy_start"}, 32'(busy), 32'd1);
    wait_end();
    check_result(eff, tag);
    corrupt_en = 1'b0;
  endtask

  function automatic logic [15:0] window(input int s, input int l);
    logic [15:0] m = '0;
    for (int i = 0; i < l; i++) m[(s + i) % 16] = 1'b1;
    return m;
  endfunction

  initial begin
    logic [15:0] m;
    rx_data = '0;
    repeat (3) tick();
    check_eq("rst_psda", 32'(psda), 32'd0);
    check_eq("rst_flags", 32'({busy, done, fail}), 32'd0);
    check_eq("rst_map", 32'(phase_ok_map), 32'd0);
    check_eq("rst_res", 32'({best_phase, eye_width, fdly}), 32'd0);
    rst_n = 1'b1;
    tick();
    pll_lock = 1'b1;
    tick();
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_dutyda", 32'(dutyda), 32'h8);

    run_sweep(16'h03E0, 1'b0, "ph5to9");
    run_sweep(16'hC003, 1'b0, "wrap");
    run_sweep(16'hFFFF, 1'b0, "all");
    run_sweep(16'h0000, 1'b0, "none");
    run_sweep(16'h01F0, 1'b1, "corrupt");

    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) m = 16'($urandom);
      else m = window($urandom_range(0, 15), $urandom_range(0, 16));
      run_sweep(m, 1'b0, "rand");
    end

    // Lock lost while settling phase 10, plus a start pulse that must be ignored.
    good_mask = 16'h0F3C;
    pulse_start();
    wait_phase(10, 3);
    check_eq("lock_map_pre", 32'(phase_ok_map), 32'(good_mask & 16'h03FF));
    pll_lock = 1'b0;
    tick();
    check_eq("lock_psda", 32'(psda), 32'd0);
    check_eq("lock_map", 32'(phase_ok_map), 32'd0);
    check_eq("lock_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    pll_lock = 1'b1;
    wait_phase(3, 12);
    pulse_start();
    check_eq("midstart_busy", 32'(busy), 32'd1);
    wait_end();
    check_result(good_mask, "relock");

    // Lock lost in DONE forces a full re-sweep.
    pll_lock = 1'b0;
    tick();
    check_eq("done_drop_done", 32'(done), 32'd0);
    check_eq("done_drop_busy", 32'(busy), 32'd1);
    pll_lock = 1'b1;
    wait_end();
    check_result(good_mask, "resweep");

    // Asynchronous reset in the middle of a SAMPLE window.
    good_mask = 16'h00FF;
    pulse_start();
    wait_phase(2, Settle + 5);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    check_eq("pre_rst_map", 32'(phase_ok_map), 32'h0003);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_flags", 32'({busy, done, fail}), 32'd0);
    check_eq("arst_psda", 32'(psda), 32'd0);
    check_eq("arst_map", 32'(phase_ok_map), 32'd0);
    check_eq("arst_res", 32'({best_phase, eye_width, fdly}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    run_sweep(16'h7800, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
